// File: rtl/if_stage_pkg.sv
// Shared widths, reset defaults and the buffered {pc, instr} entry layout
// used by the instruction-fetch stage and its buffer.
package if_stage_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [DATA_WIDTH-1:0] DEF_BOOT_ADDR = 32'h0000_0000;
  localparam logic [DATA_WIDTH-1:0] DEF_NOP_INSTR = 32'h0000_0013;
  localparam logic [DATA_WIDTH-1:0] PC_STEP       = 32'd4;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Sequential PC; wraps modulo 2^32 by construction.
  function automatic logic [DATA_WIDTH-1:0] next_pc(input logic [DATA_WIDTH-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_stage_fifo.sv
// Small instruction buffer of {pc, instr} entries between memory responses
// and the decode output register; flush beats a same-cycle push.
module if_fifo
  import if_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  fetch_entry_t             i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output fetch_entry_t             o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Storage needs no reset: count/pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited in-order
// requests, buffers responses and drives the registered decode interface.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] BOOT_ADDR  = DEF_BOOT_ADDR,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DEF_NOP_INSTR,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  instr_req_o,
  output logic [DATA_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [DATA_WIDTH-1:0] instr_rdata_i,
  input  logic                  stall_i,
  input  logic                  stall_general_i,
  input  logic                  brj_i,
  input  logic [DATA_WIDTH-1:0] brj_pc_i,
  output logic [DATA_WIDTH-1:0] d_instruction_o,
  output logic [DATA_WIDTH-1:0] d_pc_o,
  output logic [DATA_WIDTH-1:0] d_pc4_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] r_fetch_pc;
  logic [DATA_WIDTH-1:0] r_rsp_pc;
  logic [CNT_W-1:0]      r_outstanding;
  logic [CNT_W-1:0]      r_kill_cnt;

  logic                  w_redirect;
  logic                  w_handshake;
  logic                  w_keep_rsp;
  logic                  w_pop;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic [CNT_W-1:0]      w_fifo_count;
  logic [CNT_W:0]        w_in_use;
  fetch_entry_t          w_fifo_data;
  fetch_entry_t          w_push_data;

  assign w_redirect   = brj_i & ~stall_i & ~stall_general_i;
  assign w_in_use     = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  // Gating with rst_n keeps the request low while reset is held.
  assign instr_req_o  = rst_n & ~stall_general_i & ~w_redirect
                      & (w_in_use < (CNT_W + 1)'(FIFO_DEPTH));
  assign instr_addr_o = r_fetch_pc;
  assign w_handshake  = instr_req_o & instr_gnt_i;
  assign w_keep_rsp   = instr_rvalid_i & (r_kill_cnt == '0);
  assign w_pop        = ~stall_general_i & ~stall_i & ~w_redirect & ~w_fifo_empty;
  assign w_push_data  = '{pc: r_rsp_pc, instr: instr_rdata_i};

  if_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_keep_rsp),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  // Kill count is the in-flight total after this cycle's response retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= BOOT_ADDR;
      r_rsp_pc      <= BOOT_ADDR;
      r_outstanding <= '0;
      r_kill_cnt    <= '0;
    end else begin
      r_outstanding <= r_outstanding + CNT_W'(w_handshake) - CNT_W'(instr_rvalid_i);
      if (w_redirect) begin
        r_fetch_pc <= brj_pc_i;
        r_rsp_pc   <= brj_pc_i;
        r_kill_cnt <= r_outstanding - CNT_W'(instr_rvalid_i);
      end else begin
        if (w_handshake) r_fetch_pc <= next_pc(r_fetch_pc);
        if (w_keep_rsp)  r_rsp_pc   <= next_pc(r_rsp_pc);
        if (instr_rvalid_i && r_kill_cnt != '0) r_kill_cnt <= r_kill_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_instruction_o <= NOP_INSTR;
      d_pc_o          <= BOOT_ADDR;
      d_pc4_o         <= next_pc(BOOT_ADDR);
    end else if (!stall_general_i && !stall_i) begin
      if (w_redirect) begin
        d_instruction_o <= NOP_INSTR;
      end else if (!w_fifo_empty) begin
        d_instruction_o <= w_fifo_data.instr;
        d_pc_o          <= w_fifo_data.pc;
        d_pc4_o         <= next_pc(w_fifo_data.pc);
      end else begin
        d_instruction_o <= NOP_INSTR;
      end
    end
  end

  // The credit rule must make a push into a full, non-draining buffer impossible.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(w_keep_rsp && w_fifo_full && !w_pop && !w_redirect));

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: in-order memory model, expected-PC
// scoreboard and a phase table of stall/redirect stimulus.
module tb_if_stage;

   localparam logic [31:0] BOOT = 32'h0000_0000;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i = 1'b1;
   logic        instr_rvalid_i = 1'b0;
   logic [31:0] instr_rdata_i = 32'h0;
   logic        stall_i;
   logic        stall_general_i;
   logic        brj_i;
   logic [31:0] brj_pc_i;
   logic [31:0] d_instruction_o;
   logic [31:0] d_pc_o;
   logic [31:0] d_pc4_o;

   int checkCount = 0;
   int failCount  = 0;

   if_stage dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .instr_req_o     (instr_req_o),
      .instr_addr_o    (instr_addr_o),
      .instr_gnt_i     (instr_gnt_i),
      .instr_rvalid_i  (instr_rvalid_i),
      .instr_rdata_i   (instr_rdata_i),
      .stall_i         (stall_i),
      .stall_general_i (stall_general_i),
      .brj_i           (brj_i),
      .brj_pc_i        (brj_pc_i),
      .d_instruction_o (d_instruction_o),
      .d_pc_o          (d_pc_o),
      .d_pc4_o         (d_pc4_o)
   );

   always #5 clk = ~clk;

   // Instruction word stored at an address; never equals the NOP encoding here.
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return {addr[31:2], 2'b11} ^ 32'hC0DE_0000;
   endfunction

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endfunction

   // Memory model: grants recorded at the rising edge, answered in order
   // after memLatency cycles, with optional random grant back-pressure.
   typedef struct {
      logic [31:0] addr;
      int          cyc;
   } memReq_t;

   memReq_t     pending[$];
   int          cycle      = 0;
   int          memLatency = 1;
   bit          gntRandom  = 1'b0;
   logic [31:0] nextReq    = BOOT;

   always @(posedge clk) begin
      cycle++;
      if (rst_n === 1'b1) begin
         if (instr_rvalid_i) void'(pending.pop_front());
         if (instr_req_o && instr_gnt_i) begin
            check("reqAddr", instr_addr_o, nextReq);
            pending.push_back('{addr: instr_addr_o, cyc: cycle});
            nextReq = nextReq + 32'd4;
         end
      end
   end

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending.delete();
         instr_rvalid_i = 1'b0;
      end else begin
         instr_gnt_i    = gntRandom ? 1'($urandom_range(0, 1)) : 1'b1;
         instr_rvalid_i = 1'b0;
         instr_rdata_i  = 32'hDEAD_BEEF;
         if (pending.size() > 0) begin
            if (cycle - pending[0].cyc >= memLatency - 1) begin
               instr_rvalid_i = 1'b1;
               instr_rdata_i  = memWord(pending[0].addr);
            end
         end
      end
   end

   // Scoreboard: expected decode PCs, refilled from each new stream start.
   logic [31:0] expQ[$];
   logic [31:0] prevInstr, prevPc, prevPc4;
   logic        curHold, curRedirect;
   logic [31:0] curTarget;
   int          popCount = 0;

   task automatic startStream(input logic [31:0] target);
      expQ.delete();
      for (int i = 0; i < 256; i++) expQ.push_back(target + 32'(4 * i));
      nextReq = target;
   endtask

   task automatic applyStimulus(input logic s, input logic sg, input logic b, input logic [31:0] t);
      stall_i         = s;
      stall_general_i = sg;
      brj_i           = b;
      brj_pc_i        = t;
      curHold         = s | sg;
      curRedirect     = b & ~s & ~sg;
      curTarget       = t;
   endtask

   task automatic checkOutput();
      logic [31:0] expPc;
      if (curHold) begin
         check("holdInstr", d_instruction_o, prevInstr);
         check("holdPc", d_pc_o, prevPc);
         check("holdPc4", d_pc4_o, prevPc4);
      end else if (curRedirect) begin
         check("redirectNop", d_instruction_o, NOP);
         check("redirectPcHold", d_pc_o, prevPc);
      end else if (d_instruction_o == NOP) begin
         check("bubblePcHold", d_pc_o, prevPc);
      end else begin
         popCount++;
         if (expQ.size() == 0) begin
            check("scoreboardEmpty", d_pc_o, 32'hFFFF_FFFF);
         end else begin
            expPc = expQ.pop_front();
            check("decPc", d_pc_o, expPc);
            check("decInstr", d_instruction_o, memWord(expPc));
            check("decPc4", d_pc4_o, expPc + 32'd4);
         end
      end
      prevInstr = d_instruction_o;
      prevPc    = d_pc_o;
      prevPc4   = d_pc4_o;
      if (curRedirect) startStream(curTarget);
   endtask

   task automatic runCycle(input logic s, input logic sg, input logic b, input logic [31:0] t,
                           input bit reqLow);
      applyStimulus(s, sg, b, t);
      #1;
      if (reqLow) check("reqLow", {31'b0, instr_req_o}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic checkResetState();
      check("rstInstr", d_instruction_o, NOP);
      check("rstPc", d_pc_o, BOOT);
      check("rstPc4", d_pc4_o, BOOT + 32'd4);
      check("rstReq", {31'b0, instr_req_o}, 32'd0);
   endtask

   task automatic releaseReset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      startStream(BOOT);
      prevInstr = d_instruction_o;
      prevPc    = d_pc_o;
      prevPc4   = d_pc4_o;
   endtask

   typedef struct {
      int          cycles;
      logic        stall;
      logic        stallGen;
      logic        brj;
      logic [31:0] target;
      int          latency;
      bit          gntRnd;
      bit          reqLow;
      int          minPops;
      int          maxPops;
   } vec_t;

   initial begin
      vec_t vecs[15];
      int   startPops;
      int   delta;

      vecs[0]  = '{12, 0, 0, 0, 32'h0,         1, 0, 0, 6, 12};
      vecs[1]  = '{3,  1, 0, 0, 32'h0,         1, 0, 0, 0, 0};
      vecs[2]  = '{8,  0, 0, 0, 32'h0,         1, 0, 0, 3, 8};
      vecs[3]  = '{10, 0, 1, 0, 32'h0,         2, 1, 1, 0, 0};
      vecs[4]  = '{20, 0, 0, 0, 32'h0,         2, 1, 0, 2, 20};
      vecs[5]  = '{8,  0, 0, 0, 32'h0,         3, 0, 0, 1, 8};
      vecs[6]  = '{1,  0, 0, 1, 32'h100,       3, 0, 1, 0, 0};
      vecs[7]  = '{20, 0, 0, 0, 32'h0,         3, 0, 0, 4, 20};
      vecs[8]  = '{1,  1, 0, 1, 32'h200,       1, 0, 0, 0, 0};
      vecs[9]  = '{1,  0, 0, 1, 32'h300,       1, 0, 1, 0, 0};
      vecs[10] = '{12, 0, 0, 0, 32'h0,         1, 0, 0, 4, 12};
      vecs[11] = '{1,  0, 0, 1, 32'hFFFF_FFF8, 1, 0, 1, 0, 0};
      vecs[12] = '{12, 0, 0, 0, 32'h0,         1, 0, 0, 4, 12};
      vecs[13] = '{4,  1, 1, 0, 32'h0,         1, 1, 1, 0, 0};
      vecs[14] = '{10, 0, 0, 0, 32'h0,         1, 0, 0, 3, 10};

      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      checkResetState();
      releaseReset();

      // Boot: first fetched instruction reaches decode after the third edge.
      for (int i = 0; i < 3; i++) runCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("bootLatency", 32'(popCount), 32'd1);

      for (int p = 0; p < 15; p++) begin
         memLatency = vecs[p].latency;
         gntRandom  = vecs[p].gntRnd;
         startPops  = popCount;
         for (int c = 0; c < vecs[p].cycles; c++)
            runCycle(vecs[p].stall, vecs[p].stallGen, vecs[p].brj, vecs[p].target, vecs[p].reqLow);
         delta = popCount - startPops;
         checkCount++;
         if (delta < vecs[p].minPops || delta > vecs[p].maxPops) begin
            failCount++;
            $display("[TB] FAIL phase%0d pops: got %0d, expected %0d..%0d",
                     p, delta, vecs[p].minPops, vecs[p].maxPops);
         end
      end

      // Reset asserted mid-cycle while streaming takes effect immediately.
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkResetState();
      repeat (2) @(posedge clk);
      releaseReset();
      startPops = popCount;
      for (int i = 0; i < 10; i++) runCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      checkCount++;
      if (popCount - startPops < 4) begin
         failCount++;
         $display("[TB] FAIL restartPops: got %0d, expected at least 4", popCount - startPops);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
